// File: rtl/nanorv32_ahb_dmem_resp_pkg.sv
// -----------------------------------------------------------------------------
// nanorv32_ahb_dmem_resp_pkg
// Shared AHB-Lite codes, data-memory responder state encoding, the registered
// address-phase payload, and the byte-lane / legality helpers.
// -----------------------------------------------------------------------------
package nanorv32_ahb_dmem_resp_pkg;

    localparam int unsigned AHB_ADDR_W = 32;
    localparam int unsigned AHB_DATA_W = 32;
    localparam int unsigned AHB_BE_W   = AHB_DATA_W / 8;
    localparam int unsigned WCNT_W     = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        NANORV32_DRESP_IDLE = 2'b00,
        NANORV32_DRESP_WAIT = 2'b01,
        NANORV32_DRESP_ERR1 = 2'b10,
        NANORV32_DRESP_ERR2 = 2'b11
    } dresp_state_e;

    // Address-phase attributes carried into the data phase.
    typedef struct packed {
        logic [AHB_BE_W-1:0] be;
        logic                write;
    } aphase_t;

    // Little-endian byte enables for a transfer at byte offset a.
    function automatic logic [AHB_BE_W-1:0] lane_mask(input logic [1:0] a,
                                                      input logic [2:0] size);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << a;
            HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

    // Supported size, naturally aligned, and inside the RAM byte range.
    function automatic logic access_legal(input logic [AHB_ADDR_W-1:0] addr,
                                          input logic [2:0]            size,
                                          input int unsigned           addr_w);
        logic aligned;
        case (size)
            HSIZE_BYTE: aligned = 1'b1;
            HSIZE_HALF: aligned = ~addr[0];
            HSIZE_WORD: aligned = (addr[1:0] == 2'b00);
            default:    aligned = 1'b0;
        endcase
        access_legal = aligned && ((addr >> (addr_w + 2)) == '0);
    endfunction

endpackage

// File: rtl/nanorv32_ahb_dmem_resp_if.sv
// -----------------------------------------------------------------------------
// nanorv32_ahb_dmem_resp_if
// AHB-Lite data-port bundle between the core-side master and the data-memory
// responder.
//   hsel/haddr/htrans/hwrite/hsize/hwdata/hready : master -> responder
//   hreadyout/hresp/hrdata                        : responder -> master
// -----------------------------------------------------------------------------
interface nanorv32_ahb_dmem_resp_if;
    import nanorv32_ahb_dmem_resp_pkg::*;

    logic                  hsel;
    logic [AHB_ADDR_W-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [AHB_DATA_W-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [AHB_DATA_W-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/nanorv32_ahb_dmem_resp_sram.sv
// -----------------------------------------------------------------------------
// nanorv32_ahb_dmem_resp_sram
// 2**ADDR_W x 32 data RAM, four byte enables, synchronous read, write-first
// when read and write hit the same word on the same edge.
//   clk, rst           : clock, async active-high reset (read register only)
//   we/waddr/wbe/wdata : byte-enabled write port
//   re/raddr/rdata     : read port; rdata registered and held when re=0
// -----------------------------------------------------------------------------
module nanorv32_ahb_dmem_resp_sram
    import nanorv32_ahb_dmem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [AHB_BE_W-1:0]   wbe,
    input  logic [AHB_DATA_W-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [AHB_DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [AHB_DATA_W-1:0] mem [DEPTH];
    logic [AHB_DATA_W-1:0] rd_word;

    // Read word with same-edge write bytes forwarded.
    always_comb begin
        rd_word = mem[raddr];
        if (we && (waddr == raddr)) begin
            for (int i = 0; i < int'(AHB_BE_W); i++) begin
                if (wbe[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(AHB_BE_W); i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_word;
        end
    end

endmodule

// File: rtl/nanorv32_ahb_dmem_resp.sv
// -----------------------------------------------------------------------------
// nanorv32_ahb_dmem_resp
// AHB-Lite responder for the core data port backed by a byte-writable RAM.
// OKAY transfers take 1+WAIT_STATES data-phase cycles; illegal accesses get the
// two-cycle ERROR response without touching RAM or hrdata.
//   clk, rst : clock, async active-high reset
//   bus      : AHB-Lite slave modport (hreadyout/hresp/hrdata driven here)
// -----------------------------------------------------------------------------
module nanorv32_ahb_dmem_resp
    import nanorv32_ahb_dmem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    nanorv32_ahb_dmem_resp_if.slave bus
);
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_STATES);
    localparam logic [WCNT_W-1:0] CNT_ONE   = WCNT_W'(1);
    localparam bit                HAS_WAIT  = (WAIT_STATES != 0);

    dresp_state_e          state_q, state_d;
    logic [WCNT_W-1:0]     cnt_q, cnt_d;
    aphase_t               aph_q, aph_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  pend_q, pend_d;
    logic                  hreadyout_d, hresp_d;
    logic                  open_c, take_c, legal_c;
    logic                  sram_we, sram_re, launch_wait;
    logic [ADDR_W-1:0]     haddr_word, sram_raddr;
    logic [AHB_DATA_W-1:0] sram_rdata;

    assign haddr_word = bus.haddr[ADDR_W+1:2];
    assign open_c     = (state_q == NANORV32_DRESP_IDLE) || (state_q == NANORV32_DRESP_ERR2);
    assign take_c     = bus.hsel && bus.hready && open_c &&
                        ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
    assign legal_c    = access_legal(bus.haddr, bus.hsize, ADDR_W);

    // pend_q marks a legal data phase in flight; it completes in an IDLE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        aph_d   = aph_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        case (state_q)
            NANORV32_DRESP_IDLE, NANORV32_DRESP_ERR2: begin
                pend_d  = 1'b0;
                state_d = NANORV32_DRESP_IDLE;
                if (take_c) begin
                    aph_d.be    = lane_mask(bus.haddr[1:0], bus.hsize);
                    aph_d.write = bus.hwrite;
                    addr_d      = haddr_word;
                    if (!legal_c) begin
                        state_d = NANORV32_DRESP_ERR1;
                    end else begin
                        pend_d = 1'b1;
                        if (HAS_WAIT) begin
                            state_d = NANORV32_DRESP_WAIT;
                            cnt_d   = WAIT_LOAD;
                        end
                    end
                end
            end
            NANORV32_DRESP_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = NANORV32_DRESP_IDLE;
            end
            NANORV32_DRESP_ERR1: state_d = NANORV32_DRESP_ERR2;
            default:             state_d = NANORV32_DRESP_IDLE;
        endcase
        hreadyout_d = (state_d == NANORV32_DRESP_IDLE) || (state_d == NANORV32_DRESP_ERR2);
        hresp_d     = ((state_d == NANORV32_DRESP_ERR1) || (state_d == NANORV32_DRESP_ERR2))
                      ? HRESP_ERROR : HRESP_OKAY;
    end

    // State and registered bus responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= NANORV32_DRESP_IDLE;
            cnt_q         <= '0;
            aph_q         <= '0;
            addr_q        <= '0;
            pend_q        <= 1'b0;
            bus.hreadyout <= 1'b1;
            bus.hresp     <= HRESP_OKAY;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            aph_q         <= aph_d;
            addr_q        <= addr_d;
            pend_q        <= pend_d;
            bus.hreadyout <= hreadyout_d;
            bus.hresp     <= hresp_d;
        end
    end

    // Write commits on the edge that ends its data phase. Reads launch one edge
    // before completion: at the address phase when zero-wait, else at the last
    // wait cycle from the registered address.
    assign sram_we     = pend_q && (state_q == NANORV32_DRESP_IDLE) && aph_q.write;
    assign launch_wait = (state_q == NANORV32_DRESP_WAIT) && (cnt_q == CNT_ONE) && !aph_q.write;
    assign sram_re     = (take_c && legal_c && !bus.hwrite && !HAS_WAIT) || launch_wait;
    assign sram_raddr  = launch_wait ? addr_q : haddr_word;

    nanorv32_ahb_dmem_resp_sram #(.ADDR_W(ADDR_W)) u_sram (
        .clk   (clk),
        .rst   (rst),
        .we    (sram_we),
        .waddr (addr_q),
        .wbe   (aph_q.be),
        .wdata (bus.hwdata),
        .re    (sram_re),
        .raddr (sram_raddr),
        .rdata (sram_rdata)
    );

    assign bus.hrdata = sram_rdata;

endmodule

// File: tb/tb_nanorv32_ahb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_nanorv32_ahb_dmem_resp
// Two responders (zero-wait and three-wait) on a shared stimulus bus; hsel picks
// the one under test. The driver pushes the expected response when an address
// phase is accepted; the monitor pops it when the data phase completes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nanorv32_ahb_dmem_resp;
    import nanorv32_ahb_dmem_resp_pkg::*;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned RAM_BYTES = 4 << ADDR_W;
    localparam int unsigned REGION    = 256;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
        int unsigned waits;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  m_hsel;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic [1:0]  stall;
    logic [1:0]  s_hreadyout, s_hresp, s_hready;
    logic [31:0] s_hrdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        nanorv32_ahb_dmem_resp_if bus ();
        assign bus.hsel       = m_hsel[g];
        assign bus.haddr      = m_haddr;
        assign bus.htrans     = m_htrans;
        assign bus.hwrite     = m_hwrite;
        assign bus.hsize      = m_hsize;
        assign bus.hwdata     = m_hwdata;
        assign bus.hready     = bus.hreadyout & ~stall[g];
        assign s_hreadyout[g] = bus.hreadyout;
        assign s_hresp[g]     = bus.hresp;
        assign s_hready[g]    = bus.hready;
        assign s_hrdata[g]    = bus.hrdata;
        nanorv32_ahb_dmem_resp #(
            .ADDR_W      (ADDR_W),
            .WAIT_STATES ((g == 0) ? 0 : 3)
        ) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
        );
    end

    // Reference model: byte-addressed memory per responder, last read word.
    logic [7:0]  mdl [2][RAM_BYTES];
    logic [31:0] last_rd [2];
    int unsigned ws [2] = '{0, 3};
    int          cur = 0;
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got 0x%08h expected 0x%08h", name, cur, $time, act, req);
        end
    endfunction

    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] sz);
        int unsigned bytes;
        if (sz > 3'd2) return 1'b0;
        bytes = 1 << sz;
        if ((a % bytes) != 0) return 1'b0;
        return a < RAM_BYTES;
    endfunction

    task automatic xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr, input logic [31:0] wd);
        exp_t        e;
        int          n;
        int unsigned w;
        m_hsel      = '0;
        m_hsel[cur] = 1'b1;
        m_haddr     = a;
        m_htrans    = HTRANS_NONSEQ;
        m_hwrite    = wr;
        m_hsize     = sz;
        n = 0;
        @(negedge clk);
        while (!s_hready[cur] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL drv_hready_timeout dut%0d @%0t: hready stuck at 0, required 1", cur, $time);
            m_htrans = HTRANS_IDLE;
            return;
        end
        @(posedge clk);
        e.err   = 1'b0;
        e.rd    = !wr;
        e.waits = ws[cur];
        e.data  = last_rd[cur];
        if (!is_legal(a, sz)) begin
            e.err   = 1'b1;
            e.waits = 1;
        end else if (wr) begin
            for (int k = 0; k < (1 << sz); k++) begin
                w = a + k;
                mdl[cur][w] = wd[8*(w % 4) +: 8];
            end
        end else begin
            w = a & ~32'd3;
            e.data = {mdl[cur][w+3], mdl[cur][w+2], mdl[cur][w+1], mdl[cur][w]};
            last_rd[cur] = e.data;
        end
        exp_q.push_back(e);
        #1;
        m_hwdata = wd;
        m_htrans = HTRANS_IDLE;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, "_hreadyout"}, s_hreadyout[cur], 1);
        check({name, "_hresp"}, s_hresp[cur], 0);
        check({name, "_hrdata"}, s_hrdata[cur], last_rd[cur]);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int n);
        logic [31:0] a;
        logic [2:0]  sz;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin sz = HSIZE_WORD; a = $urandom_range(0, 63) * 4 + $urandom_range(1, 3); end
                    1: begin sz = HSIZE_HALF; a = $urandom_range(0, 127) * 2 + 1; end
                    2: begin sz = 3'($urandom_range(3, 7)); a = $urandom_range(0, 63) * 4; end
                    default: begin
                        sz = HSIZE_WORD;
                        a  = ($urandom_range(0, 1) == 0) ? RAM_BYTES + $urandom_range(0, 63) * 4
                                                         : 32'hFFFF_FFFC;
                    end
                endcase
            end else begin
                sz = 3'($urandom_range(0, 2));
                a  = $urandom_range(0, REGION - 1) & ~((32'd1 << sz) - 1);
            end
            xfer(a, sz, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: counts not-ready data-phase cycles, compares on completion.
    int unsigned wcnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            if (s_hreadyout[cur]) begin
                e = exp_q.pop_front();
                check("wait_cycles", wcnt, e.waits);
                check("hresp", s_hresp[cur], e.err);
                if (e.err || e.rd) check(e.err ? "err_hrdata" : "rd_hrdata", s_hrdata[cur], e.data);
                wcnt = 0;
            end else begin
                check("wait_hresp", s_hresp[cur], exp_q[0].err);
                wcnt++;
                if (wcnt > 20) begin
                    check("resp_timeout", wcnt, exp_q[0].waits);
                    void'(exp_q.pop_front());
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog @%0t: simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 2'b11;
        m_hsel   = '0;
        m_haddr  = '0;
        m_htrans = HTRANS_IDLE;
        m_hwrite = 1'b0;
        m_hsize  = HSIZE_WORD;
        m_hwdata = '0;
        stall    = '0;
        last_rd  = '{32'd0, 32'd0};
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            cur = d;
            check("rst_hreadyout", s_hreadyout[d], 1);
            check("rst_hresp", s_hresp[d], 0);
            check("rst_hrdata", s_hrdata[d], 0);
        end
        rst = 2'b00;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            cur = d;
            idle_check("post_rst");
        end

        // Known contents for the exercised region of both RAMs.
        for (int d = 0; d < 2; d++) begin
            cur = d;
            for (int w = 0; w < int'(REGION / 4); w++) xfer(w * 4, HSIZE_WORD, 1'b1, $urandom);
            drain();
        end

        // Zero-wait responder: directed cases.
        cur = 0;
        xfer(32'h10, HSIZE_WORD, 1'b1, 32'hDEAD_BEEF);
        xfer(32'h10, HSIZE_WORD, 1'b0, 32'h0);
        drain();
        check("t1_hrdata", s_hrdata[0], 32'hDEAD_BEEF);
        xfer(32'h20, HSIZE_WORD, 1'b1, 32'h1122_3344);
        @(posedge clk);
        #1;
        xfer(32'h21, HSIZE_BYTE, 1'b1, 32'h0000_AA00);
        xfer(32'h20, HSIZE_WORD, 1'b0, 32'h0);
        drain();
        check("t2_hrdata", s_hrdata[0], 32'h1122_AA44);

        xfer(32'h2, HSIZE_WORD, 1'b1, 32'hFFFF_FFFF);
        xfer(32'h1, HSIZE_HALF, 1'b1, 32'hFFFF_FFFF);
        xfer(32'h0, 3'b011, 1'b1, 32'hFFFF_FFFF);
        xfer(RAM_BYTES, HSIZE_WORD, 1'b1, 32'hFFFF_FFFF);
        xfer(32'h6, HSIZE_WORD, 1'b0, 32'h0);
        xfer(32'h0, HSIZE_WORD, 1'b0, 32'h0);
        xfer(32'h4, HSIZE_WORD, 1'b0, 32'h0);
        drain();

        m_hsel[0] = 1'b1;
        m_haddr   = 32'h10;
        m_hwrite  = 1'b1;
        m_hsize   = HSIZE_WORD;
        m_hwdata  = 32'hFFFF_FFFF;
        m_htrans  = HTRANS_BUSY;
        idle_check("busy");
        idle_check("busy");
        m_htrans  = HTRANS_NONSEQ;
        m_hsel    = '0;
        idle_check("unsel");
        idle_check("unsel");
        m_hsel[0] = 1'b1;
        stall[0]  = 1'b1;
        idle_check("stall");
        idle_check("stall");
        m_htrans  = HTRANS_IDLE;
        stall[0]  = 1'b0;
        xfer(32'h10, HSIZE_WORD, 1'b0, 32'h0);
        drain();

        rand_run(200);
        drain();

        // Three-wait responder.
        cur = 1;
        xfer(32'h0, HSIZE_WORD, 1'b0, 32'h0);
        xfer(32'h4, HSIZE_WORD, 1'b0, 32'h0);
        xfer(32'h3, HSIZE_HALF, 1'b0, 32'h0);
        drain();
        rand_run(150);
        drain();

        // Reset during the wait cycles of a write.
        m_hsel    = 2'b10;
        m_haddr   = 32'h30;
        m_htrans  = HTRANS_NONSEQ;
        m_hwrite  = 1'b1;
        m_hsize   = HSIZE_WORD;
        @(posedge clk);
        #1;
        m_hwdata  = 32'h5A5A_5A5A;
        m_htrans  = HTRANS_IDLE;
        @(posedge clk);
        #1;
        check("t6_in_wait", s_hreadyout[1], 0);
        rst[1] = 1'b1;
        #1;
        check("t6_hreadyout", s_hreadyout[1], 1);
        check("t6_hresp", s_hresp[1], 0);
        check("t6_hrdata", s_hrdata[1], 0);
        @(negedge clk);
        rst[1]     = 1'b0;
        last_rd[1] = 32'd0;
        @(posedge clk);
        #1;
        xfer(32'h30, HSIZE_WORD, 1'b0, 32'h0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
